// File: rtl/alu_seq_core.sv
// Sequential ALU core: fetches operands over a request/acknowledge register bus, executes one opcode, reports flags.
// Optional write-back of the result to the destination register when ALU_WRITEBACK_EN is defined.
module alu_seq_core #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic                                               instr_valid,
  input  logic [3:0]                                         instr_opcode,
  input  logic [((DATA_W > ADDR_W) ? DATA_W : ADDR_W)-1:0]   instr_operand,
  output logic [3:0]                                         bus_req,
  output logic [ADDR_W-1:0]                                  bus_addr,
  output logic [DATA_W-1:0]                                  bus_wdata,
  input  logic                                               bus_ack,
  input  logic [DATA_W-1:0]                                  bus_rdata,
  input  logic                                               result_oe_n,
  output logic [DATA_W-1:0]                                  result,
  output logic                                               result_oe,
  output logic                                               carry,
  output logic                                               zero,
  output logic                                               err,
  output logic                                               busy,
  output logic                                               done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_NEXT,
    S_RSRC,
    S_RDST,
    S_EXEC,
`ifdef ALU_WRITEBACK_EN
    S_WB,
`endif
    S_DONE
  } state_t;

  typedef enum logic [3:0] {
    OP_ADDI = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUBI = 4'd3,
    OP_SUB  = 4'd4,
    OP_NAND = 4'd5,
    OP_SHR  = 4'd6,
    OP_SHL  = 4'd7,
    OP_XOR  = 4'd8
  } op_t;

  localparam logic [3:0]        REQ_NONE  = 4'b0000;
  localparam logic [3:0]        REQ_READ  = 4'b0001;
  localparam logic [3:0]        REQ_WRITE = 4'b0010;
  localparam logic [3:0]        REQ_NEXT  = 4'b0011;
  localparam logic [DATA_W-1:0] SH_LIM    = DATA_W[DATA_W-1:0];

  state_t              state_q, state_d;
  logic [3:0]          opcode_q, opcode_d;
  logic [ADDR_W-1:0]   src_addr_q, src_addr_d;
  logic [ADDR_W-1:0]   dst_addr_q, dst_addr_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                carry_q, carry_d;
  logic                zero_q, zero_d;
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic [3:0]          bus_req_q, bus_req_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W:0]     sum, diff;
  logic                op_legal, op_regform;

  always_comb begin
    op_legal   = (instr_opcode >= 4'd1) && (instr_opcode <= 4'd8);
    op_regform = (opcode_q == OP_ADD) || (opcode_q == OP_SUB) ||
                 (opcode_q == OP_NAND) || (opcode_q == OP_XOR);
    sum  = {1'b0, b_q} + {1'b0, a_q};
    diff = {1'b0, b_q} - {1'b0, a_q};
  end

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    src_addr_d = src_addr_q;
    dst_addr_d = dst_addr_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          opcode_d   = instr_opcode;
          src_addr_d = instr_operand[ADDR_W-1:0];
          a_d        = instr_operand[DATA_W-1:0];
          if (op_legal) begin
            err_d   = 1'b0;
            state_d = S_NEXT;
          end else begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_NEXT: begin
        if (bus_ack) begin
          dst_addr_d = ADDR_W'(bus_rdata);
          state_d    = op_regform ? S_RSRC : S_RDST;
        end
      end
      S_RSRC: begin
        if (bus_ack) begin
          a_d     = bus_rdata;
          state_d = S_RDST;
        end
      end
      S_RDST: begin
        if (bus_ack) begin
          b_d     = bus_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        carry_d = 1'b0;
        case (opcode_q)
          OP_ADDI, OP_ADD: begin
            result_d = sum[DATA_W-1:0];
            carry_d  = sum[DATA_W];
          end
          OP_SUBI, OP_SUB: begin
            // The extra top bit of the widened difference is the borrow (A > B).
            result_d = diff[DATA_W-1:0];
            carry_d  = diff[DATA_W];
          end
          OP_NAND: result_d = ~(b_q & a_q);
          OP_XOR:  result_d = b_q ^ a_q;
          OP_SHR:  result_d = (a_q >= SH_LIM) ? '0 : (b_q >> a_q);
          OP_SHL:  result_d = (a_q >= SH_LIM) ? '0 : (b_q << a_q);
          default: result_d = result_q;
        endcase
        zero_d = (result_d == '0);
`ifdef ALU_WRITEBACK_EN
        state_d = S_WB;
`else
        state_d = S_DONE;
`endif
      end
`ifdef ALU_WRITEBACK_EN
      S_WB: begin
        if (bus_ack) state_d = S_DONE;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so they are valid from state entry.
  always_comb begin
    bus_req_d  = REQ_NONE;
    bus_addr_d = '0;
    done_d     = (state_d == S_DONE);
    case (state_d)
      S_NEXT: bus_req_d = REQ_NEXT;
      S_RSRC: begin
        bus_req_d  = REQ_READ;
        bus_addr_d = src_addr_d;
      end
      S_RDST: begin
        bus_req_d  = REQ_READ;
        bus_addr_d = dst_addr_d;
      end
`ifdef ALU_WRITEBACK_EN
      S_WB: begin
        bus_req_d  = REQ_WRITE;
        bus_addr_d = dst_addr_d;
      end
`endif
      default: bus_req_d = REQ_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      opcode_q   <= '0;
      src_addr_q <= '0;
      dst_addr_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      bus_req_q  <= REQ_NONE;
      bus_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      src_addr_q <= src_addr_d;
      dst_addr_q <= dst_addr_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      err_q      <= err_d;
      done_q     <= done_d;
      bus_req_q  <= bus_req_d;
      bus_addr_q <= bus_addr_d;
    end
  end

`ifdef ALU_WRITEBACK_EN
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;

  always_comb begin
    bus_wdata_d = '0;
    if (state_d == S_WB) bus_wdata_d = result_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus_wdata_q <= '0;
    else        bus_wdata_q <= bus_wdata_d;
  end

  assign bus_wdata = bus_wdata_q;
`else
  assign bus_wdata = '0;
`endif

  assign bus_req   = bus_req_q;
  assign bus_addr  = bus_addr_q;
  assign result    = result_q;
  assign result_oe = ~result_oe_n;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign err       = err_q;
  assign done      = done_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_seq_core.sv
// Bench for alu_seq_core: register-file emulator on the bus plus an arithmetic reference model.
module tb_alu_seq_core;
`ifdef ALU_WRITEBACK_EN
  localparam int DW = 8;
  localparam bit WB = 1'b1;
`else
  localparam int DW = 4;
  localparam bit WB = 1'b0;
`endif
  localparam int AW  = 4;
  localparam int OPW = (DW > AW) ? DW : AW;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           instr_valid;
  logic [3:0]     instr_opcode;
  logic [OPW-1:0] instr_operand;
  logic [3:0]     bus_req;
  logic [AW-1:0]  bus_addr;
  logic [DW-1:0]  bus_wdata;
  logic           bus_ack;
  logic [DW-1:0]  bus_rdata;
  logic           result_oe_n;
  logic [DW-1:0]  result;
  logic           result_oe, carry, zero, err, busy, done;

  alu_seq_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_opcode(instr_opcode),
    .instr_operand(instr_operand), .bus_req(bus_req), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .result_oe_n(result_oe_n), .result(result), .result_oe(result_oe), .carry(carry),
    .zero(zero), .err(err), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // register-file emulator state
  logic [DW-1:0] regs [16];
  int   nxt_addr   = 3;
  int   stall_addr = -1;
  int   stall_n    = 0;
  bit   rand_wait  = 1'b0;
  bit   in_req     = 1'b0;
  bit   unstable   = 1'b0;
  int   cnt, tgt, total_waits;
  logic [3:0]    cur_req;
  logic [AW-1:0] cur_addr;
  int   log_req[$], log_addr[$], log_wd[$];

  // reference model state
  int m_res = 0, m_c = 0, m_z = 0, m_e = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      bus_ack = 1'b0;
      in_req  = 1'b0;
    end else begin
      if (bus_ack) in_req = 1'b0;
      bus_ack = 1'b0;
      if (bus_req != 4'b0000) begin
        if (!in_req) begin
          in_req   = 1'b1;
          cnt      = 0;
          cur_req  = bus_req;
          cur_addr = bus_addr;
          if (rand_wait) tgt = int'($urandom_range(0, 2));
          else if (bus_req == 4'b0001 && int'(bus_addr) == stall_addr) tgt = stall_n;
          else tgt = 0;
        end else if (bus_req !== cur_req || bus_addr !== cur_addr) begin
          unstable = 1'b1;
        end
        if (cnt >= tgt) begin
          bus_ack   = 1'b1;
          bus_rdata = (bus_req == 4'b0011) ? DW'(nxt_addr) : regs[bus_addr];
          log_req.push_back(int'(bus_req));
          log_addr.push_back(int'(bus_addr));
          log_wd.push_back(int'(bus_wdata));
        end else begin
          cnt++;
          total_waits++;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_result"}, 32'(result), 0);
    chk({tag, "_carry"}, 32'(carry), 0);
    chk({tag, "_zero"}, 32'(zero), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_req"}, 32'(bus_req), 0);
    chk({tag, "_addr"}, 32'(bus_addr), 0);
    chk({tag, "_wdata"}, 32'(bus_wdata), 0);
  endtask

  task automatic run(input int op, input int opnd, input int dst, input string tag, input bit poke);
    int mask, a, b, n, nexp;
    bit legal, regf;
    int ereq[$], eaddr[$], ewd[$];
    mask  = (1 << DW) - 1;
    legal = (op >= 1 && op <= 8);
    regf  = (op == 2 || op == 4 || op == 5 || op == 8);
    b = int'(regs[dst]);
    a = regf ? int'(regs[opnd & 15]) : (opnd & mask);
    if (legal) begin
      case (op)
        1, 2: begin m_res = (b + a) & mask; m_c = ((b + a) >> DW) & 1; end
        3, 4: begin m_res = (b - a) & mask; m_c = (a > b) ? 1 : 0; end
        5: begin m_res = ~(b & a) & mask; m_c = 0; end
        6: begin m_res = (a >= DW) ? 0 : (b >> a); m_c = 0; end
        7: begin m_res = (a >= DW) ? 0 : ((b << a) & mask); m_c = 0; end
        default: begin m_res = b ^ a; m_c = 0; end
      endcase
      m_z = (m_res == 0) ? 1 : 0;
      m_e = 0;
      ereq.push_back(3); eaddr.push_back(-1); ewd.push_back(-1);
      if (regf) begin ereq.push_back(1); eaddr.push_back(opnd & 15); ewd.push_back(-1); end
      ereq.push_back(1); eaddr.push_back(dst); ewd.push_back(-1);
      if (WB) begin ereq.push_back(2); eaddr.push_back(dst); ewd.push_back(m_res); end
      nexp = (regf ? 5 : 4) + (WB ? 1 : 0);
    end else begin
      m_e  = 1;
      nexp = 1;
    end

    nxt_addr = dst;
    total_waits = 0;
    unstable = 1'b0;
    log_req.delete(); log_addr.delete(); log_wd.delete();
    @(negedge clk);
    instr_valid   = 1'b1;
    instr_opcode  = 4'(op);
    instr_operand = OPW'(opnd);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) instr_valid = poke;
      if (n == 3) instr_valid = 1'b0;
    end while (!done && n < 100);
    instr_valid = 1'b0;

    chk({tag, "_latency"}, 32'(n), 32'(nexp + total_waits));
    chk({tag, "_result"}, 32'(result), 32'(m_res));
    chk({tag, "_carry"}, 32'(carry), 32'(m_c));
    chk({tag, "_zero"}, 32'(zero), 32'(m_z));
    chk({tag, "_err"}, 32'(err), 32'(m_e));
    chk({tag, "_stable"}, 32'(unstable), 0);
    chk({tag, "_nreq"}, 32'(log_req.size()), 32'(ereq.size()));
    for (int i = 0; i < ereq.size() && i < log_req.size(); i++) begin
      chk($sformatf("%s_req%0d", tag, i), 32'(log_req[i]), 32'(ereq[i]));
      if (eaddr[i] >= 0) chk($sformatf("%s_addr%0d", tag, i), 32'(log_addr[i]), 32'(eaddr[i]));
      if (ewd[i] >= 0) chk($sformatf("%s_wdata%0d", tag, i), 32'(log_wd[i]), 32'(ewd[i]));
    end
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 32'(done), 0);
    chk({tag, "_idle"}, 32'(busy), 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) regs[i] = DW'(i * 5 + 7);
    regs[1] = DW'(4); regs[2] = DW'(5); regs[3] = DW'(6); regs[4] = DW'(3);
    rst_n = 1'b0; instr_valid = 1'b0; instr_opcode = '0; instr_operand = '0;
    result_oe_n = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    run(1, 2, 3, "addi2", 1'b0);
`ifndef ALU_WRITEBACK_EN
    chk("addi2_const", 32'(result), 8);
`endif
    run(1, 15, 3, "addi15", 1'b0);
`ifndef ALU_WRITEBACK_EN
    chk("addi15_const", 32'({carry, result}), 32'h15);
`endif
    run(2, 2, 3, "add_r2", 1'b0);
`ifndef ALU_WRITEBACK_EN
    chk("add_r2_const", 32'(result), 11);
`endif
    run(4, 4, 3, "sub_r4", 1'b0);
    run(5, 1, 3, "nand_r1", 1'b0);
`ifndef ALU_WRITEBACK_EN
    chk("nand_r1_const", 32'(result), 32'hb);
`endif
    run(3, 7, 3, "subi7", 1'b0);
    run(3, 6, 3, "subi6", 1'b0);
    run(6, 2, 3, "shr2", 1'b0);
    run(7, 1, 3, "shl1", 1'b0);
    run(6, 4, 3, "shr4", 1'b0);
    run(15, 0, 3, "illegal15", 1'b0);
    run(8, 2, 3, "xor_poke", 1'b1);

    stall_addr = 3; stall_n = 3;
    run(1, 2, 3, "stall_rdst", 1'b0);
    chk("stall_waits", 32'(total_waits), 3);
    stall_addr = -1; stall_n = 0;

    result_oe_n = 1'b1; #1;
    chk("oe_off", 32'(result_oe), 0);
    chk("oe_off_result", 32'(result), 32'(m_res));
    result_oe_n = 1'b0; #1;
    chk("oe_on", 32'(result_oe), 1);

    // abort an ADD while its source read is stalled
    stall_addr = 2; stall_n = 5; nxt_addr = 3;
    @(negedge clk);
    instr_valid = 1'b1; instr_opcode = 4'd2; instr_operand = OPW'(2);
    n = 0;
    repeat (2) begin @(posedge clk); #1; n++; instr_valid = 1'b0; end
    chk("rsrc_req", 32'(bus_req), 1);
    chk("rsrc_addr", 32'(bus_addr), 2);
    rst_n = 1'b0; #1;
    chk_all_zero("midreset");
    m_res = 0; m_c = 0; m_z = 0; m_e = 0;
    stall_addr = -1; stall_n = 0;
    @(negedge clk); rst_n = 1'b1;

`ifdef ALU_WRITEBACK_EN
    regs[3] = DW'(100);
    run(1, 200, 3, "wb_addi200", 1'b0);
    chk("wb_addi200_const", 32'({carry, result}), 32'h12c);
`endif

    for (int i = 0; i < 16; i++) regs[i] = DW'($urandom);
    rand_wait = 1'b1;
    for (int k = 0; k < 40; k++) begin
      int op;
      op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(1, 8));
      run(op, int'($urandom_range(0, (1 << OPW) - 1)), int'($urandom_range(0, 15)),
          $sformatf("rnd%0d", k), 1'($urandom_range(0, 1)) & (op >= 1 && op <= 8));
    end
    rand_wait = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

endmodule
